// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial unsigned subtractor. A single 1-bit full-subtractor cell is
// reused once per clock, LSB first, with a registered borrow between bits.
// One subtraction takes WIDTH cycles in RUN plus one DONE cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request an operation; honoured only in IDLE or DONE
//   a_in       minuend, captured on the accepting edge
//   b_in       subtrahend, captured on the accepting edge
//   busy       high while the operation is iterating (RUN)
//   done       one-cycle pulse; diff/borrow_out valid from this cycle
//   diff       (a - b) mod 2^WIDTH, held until the next completion
//   borrow_out final borrow, 1 when a < b (unsigned)
//   zero_flag  (SUB_FLAGS_EN only) diff == 0
//   eq_lt      (SUB_FLAGS_EN only) [1] a == b, [0] a < b
//
// Optional feature: define SUB_FLAGS_EN to add zero_flag and eq_lt.

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_FLAGS_EN
    output logic             zero_flag,
    output logic [1:0]       eq_lt,
`endif
    output logic             borrow_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 bits produced so far; the final bit is merged in
    // directly on the completion edge, so no extra shift stage is needed.
    logic [WIDTH-2:0] res_sh;
    logic [CNT_W-1:0] cnt;
    logic             bor;

    logic             a0;
    logic             b0;
    logic             d;
    logic             bor_next;
    logic [WIDTH-1:0] res_cat;

`ifdef SUB_FLAGS_EN
    logic             any_one;
`endif

    // Full subtractor: two half-subtractor stages with the borrows ORed.
    always_comb begin
        a0       = a_sh[0];
        b0       = b_sh[0];
        d        = a0 ^ b0 ^ bor;
        bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor);
        res_cat  = {d, res_sh};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            cnt        <= '0;
            bor        <= 1'b0;
`ifdef SUB_FLAGS_EN
            any_one    <= 1'b0;
            zero_flag  <= 1'b0;
            eq_lt      <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        res_sh  <= '0;
                        bor     <= 1'b0;
                        cnt     <= '0;
`ifdef SUB_FLAGS_EN
                        any_one <= 1'b0;
`endif
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_cat[WIDTH-1:1];
                    bor     <= bor_next;
                    cnt     <= cnt + CNT_W'(1);
`ifdef SUB_FLAGS_EN
                    any_one <= any_one | d;
`endif
                    if (cnt == LAST_BIT) begin
                        diff       <= res_cat;
                        borrow_out <= bor_next;
`ifdef SUB_FLAGS_EN
                        // diff == 0 exactly when a == b, so the sticky
                        // OR serves both zero_flag and eq_lt[1].
                        zero_flag  <= ~(any_one | d);
                        eq_lt      <= {~(any_one | d), bor_next};
`endif
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl
// Scoreboard bench for serial_subtractor_ctrl with a WIDTH=4 and a WIDTH=8
// instance. Expected results are pushed when an operation is launched and
// popped on each done pulse.

module tb_serial_subtractor_ctrl;

    typedef struct {
        logic [7:0] diff;
        logic       bor;
        logic       zero;
        logic [1:0] eqlt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, start4, busy4, done4, bor4;
    logic [3:0] a4, b4, diff4;
    logic       rst8, start8, busy8, done8, bor8;
    logic [7:0] a8, b8, diff8;
`ifdef SUB_FLAGS_EN
    logic       zero4, zero8;
    logic [1:0] eqlt4, eqlt8;
`endif

    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a_in(a4), .b_in(b4),
        .busy(busy4), .done(done4), .diff(diff4),
`ifdef SUB_FLAGS_EN
        .zero_flag(zero4), .eq_lt(eqlt4),
`endif
        .borrow_out(bor4)
    );

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .diff(diff8),
`ifdef SUB_FLAGS_EN
        .zero_flag(zero8), .eq_lt(eqlt8),
`endif
        .borrow_out(bor8)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    exp_t q4[$];
    exp_t q8[$];
    logic [7:0] last_diff4 = '0;
    logic [7:0] last_diff8 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned w);
        exp_t e;
        int unsigned mask;
        mask   = (1 << w) - 1;
        e.diff = 8'((a - b) & mask);
        e.bor  = (a < b);
        e.zero = (a == b);
        e.eqlt = {a == b, a < b};
        return e;
    endfunction

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            check("busy_with_done4", {31'd0, busy4}, 32'd0);
            if (q4.size() == 0) begin
                check("unexpected_done4", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                check("diff4", {28'd0, diff4}, {24'd0, e.diff});
                check("borrow4", {31'd0, bor4}, {31'd0, e.bor});
`ifdef SUB_FLAGS_EN
                check("zero4", {31'd0, zero4}, {31'd0, e.zero});
                check("eqlt4", {30'd0, eqlt4}, {30'd0, e.eqlt});
`endif
                last_diff4 = e.diff;
            end
        end else if (busy4) begin
            check("diff_hold4", {28'd0, diff4}, {24'd0, last_diff4});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            check("busy_with_done8", {31'd0, busy8}, 32'd0);
            if (q8.size() == 0) begin
                check("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("diff8", {24'd0, diff8}, {24'd0, e.diff});
                check("borrow8", {31'd0, bor8}, {31'd0, e.bor});
`ifdef SUB_FLAGS_EN
                check("zero8", {31'd0, zero8}, {31'd0, e.zero});
                check("eqlt8", {30'd0, eqlt8}, {30'd0, e.eqlt});
`endif
                last_diff8 = e.diff;
            end
        end else if (busy8) begin
            check("diff_hold8", {24'd0, diff8}, {24'd0, last_diff8});
        end
    end

    // One WIDTH=4 operation from IDLE with a single-cycle start pulse.
    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        @(posedge clk); #1;
        a4 = a; b4 = b; start4 = 1'b1;
        q4.push_back(model(a, b, 4));
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        repeat (5) @(posedge clk);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q4.size() != 0 || q8.size() != 0)
            check("drain_timeout", q4.size() + q8.size(), 32'd0);
    endtask

    initial begin
        rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1; rst4 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_done4", {31'd0, done4}, 32'd0);
        check("rst_diff4", {28'd0, diff4}, 32'd0);
        check("rst_bor4", {31'd0, bor4}, 32'd0);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_diff8", {24'd0, diff8}, 32'd0);
`ifdef SUB_FLAGS_EN
        check("rst_zero8", {31'd0, zero8}, 32'd0);
        check("rst_eqlt8", {30'd0, eqlt8}, 32'd0);
`endif

        // 5 - 3 with cycle-accurate latency checks.
        @(posedge clk); #1;
        a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
        q4.push_back(model(5, 3, 4));
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lat_busy", {31'd0, busy4}, 32'd1);
            check("lat_nodone", {31'd0, done4}, 32'd0);
        end
        @(negedge clk);
        check("lat_done", {31'd0, done4}, 32'd1);
        check("lat_busy_low", {31'd0, busy4}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done4}, 32'd0);

        op4(4'd3, 4'd5);
        op4(4'd15, 4'd15);
        op4(4'd0, 4'd0);
        op4(4'd0, 4'd15);
        op4(4'd15, 4'd0);

        // Back-to-back on WIDTH=8 with start held high and operand noise.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
        q8.push_back(model(200, 55, 8));
        @(posedge clk); #1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        repeat (7) @(posedge clk);
        #1; a8 = 8'($urandom); b8 = 8'($urandom);
        @(posedge clk); #1;
        check("b2b_done1", {31'd0, done8}, 32'd1);
        a8 = 8'd55; b8 = 8'd200;
        q8.push_back(model(55, 200, 8));
        @(posedge clk); #1;
        check("b2b_rerun_busy", {31'd0, busy8}, 32'd1);
        check("b2b_rerun_nodone", {31'd0, done8}, 32'd0);
        a8 = 8'($urandom); b8 = 8'($urandom);
        repeat (7) @(posedge clk);
        #1; a8 = 8'($urandom);
        @(posedge clk); #1;
        check("b2b_done2", {31'd0, done8}, 32'd1);
        start8 = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle_busy", {31'd0, busy8}, 32'd0);
        check("b2b_idle_done", {31'd0, done8}, 32'd0);

        // Reset on the third RUN cycle aborts without a done pulse.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        last_diff8 = '0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_diff", {24'd0, diff8}, 32'd0);
        check("abort_bor", {31'd0, bor8}, 32'd0);
        repeat (12) @(posedge clk);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
        q8.push_back(model(9, 9, 8));
        @(posedge clk); #1;
        start8 = 1'b0;
        drain(40);

        // Exhaustive WIDTH=4 sweep.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op4(4'(a), 4'(b));
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
